// File: rtl/drg_pkg.sv
// Shared encodings for the multi-channel ramp generator: ramp modes and
// configuration register addresses.
package drg_pkg;

  typedef enum logic [1:0] {
    DRG_MODE_SAW    = 2'd0,
    DRG_MODE_TRI    = 2'd1,
    DRG_MODE_SINGLE = 2'd2,
    DRG_MODE_RSVD   = 2'd3
  } drg_mode_e;

  localparam logic [2:0] DRG_ADDR_START = 3'd0;
  localparam logic [2:0] DRG_ADDR_END   = 3'd1;
  localparam logic [2:0] DRG_ADDR_STEP  = 3'd2;
  localparam logic [2:0] DRG_ADDR_DWELL = 3'd3;
  localparam logic [2:0] DRG_ADDR_MODE  = 3'd4;

endpackage

// File: rtl/drg_channel.sv
// One ramp channel: shadow/active parameter sets, dwell counter, step datapath
// and wrap/done flags. Triangle support is built only with DRG_TRIANGLE_EN.
module drg_channel
  import drg_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [2:0]       i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_commit,
  input  logic             i_run_en,
  input  logic             i_restart,
  output logic [WIDTH-1:0] o_ramp,
  output logic             o_wrap,
  output logic             o_done
);

  logic [WIDTH-1:0]     r_sh_start, r_sh_end, r_sh_step;
  logic [CNT_WIDTH-1:0] r_sh_dwell;
  drg_mode_e            r_sh_mode;
  logic [WIDTH-1:0]     r_start, r_end, r_step;
  logic [CNT_WIDTH-1:0] r_dwell;
  drg_mode_e            r_mode;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_out;
  logic                 r_wrap, r_done;

  logic [CNT_WIDTH-1:0] w_dwell_wdata;
  logic [WIDTH:0]       w_up_sum;
  logic                 w_up_ok, w_degenerate, w_frozen;
  logic [WIDTH-1:0]     w_nxt_out;
  logic [CNT_WIDTH-1:0] w_nxt_cnt;
  logic                 w_nxt_wrap, w_nxt_done;

  generate
    if (CNT_WIDTH > WIDTH) begin : g_dw_ext
      assign w_dwell_wdata = {{(CNT_WIDTH-WIDTH){1'b0}}, i_wdata};
    end else begin : g_dw_trunc
      assign w_dwell_wdata = i_wdata[CNT_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_start <= '0;
      r_sh_end   <= '0;
      r_sh_step  <= '0;
      r_sh_dwell <= '0;
      r_sh_mode  <= DRG_MODE_SAW;
    end else if (i_wen) begin
      case (i_addr)
        DRG_ADDR_START: r_sh_start <= i_wdata;
        DRG_ADDR_END:   r_sh_end   <= i_wdata;
        DRG_ADDR_STEP:  r_sh_step  <= i_wdata;
        DRG_ADDR_DWELL: r_sh_dwell <= w_dwell_wdata;
        DRG_ADDR_MODE:  r_sh_mode  <= drg_mode_e'(i_wdata[1:0]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= '0;
      r_end   <= '0;
      r_step  <= '0;
      r_dwell <= '0;
      r_mode  <= DRG_MODE_SAW;
    end else if (i_commit) begin
      r_start <= r_sh_start;
      r_end   <= r_sh_end;
      r_step  <= r_sh_step;
      r_dwell <= r_sh_dwell;
      r_mode  <= r_sh_mode;
    end
  end

  // Extra top bit catches carry out of the up-step.
  assign w_up_sum     = {1'b0, r_out} + {1'b0, r_step};
  assign w_up_ok      = !w_up_sum[WIDTH] && (w_up_sum[WIDTH-1:0] <= r_end);
  assign w_degenerate = (r_start >= r_end);
  assign w_frozen     = (r_mode == DRG_MODE_SINGLE) && r_done;

`ifdef DRG_TRIANGLE_EN
  logic           r_down;
  logic           w_nxt_down;
  logic [WIDTH:0] w_dn_diff;
  logic           w_dn_ok;

  assign w_dn_diff = {1'b0, r_out} - {1'b0, r_step};
  assign w_dn_ok   = !w_dn_diff[WIDTH] && (w_dn_diff[WIDTH-1:0] >= r_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_down <= 1'b0;
    else     r_down <= w_nxt_down;
  end
`endif

  always_comb begin
    w_nxt_out  = r_out;
    w_nxt_cnt  = r_cnt;
    w_nxt_wrap = 1'b0;
    w_nxt_done = r_done;
`ifdef DRG_TRIANGLE_EN
    w_nxt_down = r_down;
`endif
    if (i_commit || i_restart) begin
      // Commit loads the new START straight from the shadow set.
      w_nxt_out  = i_commit ? r_sh_start : r_start;
      w_nxt_cnt  = '0;
      w_nxt_done = 1'b0;
`ifdef DRG_TRIANGLE_EN
      w_nxt_down = 1'b0;
`endif
    end else if (i_run_en && !w_frozen) begin
      if (r_cnt != r_dwell) begin
        w_nxt_cnt = r_cnt + 1'b1;
      end else begin
        w_nxt_cnt = '0;
        if (w_degenerate) begin
          if (r_mode == DRG_MODE_SINGLE) w_nxt_done = 1'b1;
`ifdef DRG_TRIANGLE_EN
        end else if (r_down) begin
          if (w_dn_ok) begin
            w_nxt_out = w_dn_diff[WIDTH-1:0];
          end else begin
            w_nxt_out  = r_start;
            w_nxt_down = 1'b0;
            w_nxt_wrap = 1'b1;
          end
`endif
        end else if (w_up_ok) begin
          w_nxt_out = w_up_sum[WIDTH-1:0];
        end else begin
          case (r_mode)
            DRG_MODE_SINGLE: begin
              w_nxt_out  = r_end;
              w_nxt_done = 1'b1;
            end
`ifdef DRG_TRIANGLE_EN
            DRG_MODE_TRI: begin
              w_nxt_out  = r_end;
              w_nxt_down = 1'b1;
            end
`endif
            default: begin
              w_nxt_out  = r_start;
              w_nxt_wrap = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_out  <= w_nxt_out;
      r_cnt  <= w_nxt_cnt;
      r_wrap <= w_nxt_wrap;
      r_done <= w_nxt_done;
    end
  end

  assign o_ramp = r_out;
  assign o_wrap = r_wrap;
  assign o_done = r_done;

endmodule

// File: rtl/drg_multi.sv
// Multi-channel digital ramp generator top: decodes the config channel select
// and packs per-channel outputs. Optional triangle mode: DRG_TRIANGLE_EN.
module drg_multi
  import drg_pkg::*;
#(
  parameter int  CH_NUM    = 3,
  parameter int  WIDTH     = 32,
  parameter int  CNT_WIDTH = 32,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wen,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [2:0]              cfg_addr,
  input  logic [WIDTH-1:0]        cfg_wdata,
  input  logic                    cfg_commit,
  input  logic [CH_NUM-1:0]       run_en,
  input  logic [CH_NUM-1:0]       restart,
  output logic [CH_NUM*WIDTH-1:0] ramp_out,
  output logic [CH_NUM-1:0]       ramp_wrap,
  output logic [CH_NUM-1:0]       ramp_done
);

  logic [CH_NUM-1:0] w_wen;

  // Out-of-range channel selects match no lane and are dropped.
  generate
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      assign w_wen[g] = cfg_wen && (cfg_ch == CH_W'(g));

      drg_channel #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
      ) u_channel (
        .clk       (clk),
        .rst       (rst),
        .i_wen     (w_wen[g]),
        .i_addr    (cfg_addr),
        .i_wdata   (cfg_wdata),
        .i_commit  (cfg_commit),
        .i_run_en  (run_en[g]),
        .i_restart (restart[g]),
        .o_ramp    (ramp_out[g*WIDTH +: WIDTH]),
        .o_wrap    (ramp_wrap[g]),
        .o_done    (ramp_done[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_drg_multi.sv
// Bench for drg_multi: table-driven sawtooth plus hand sequences for triangle,
// single-shot, shadow/commit, isolation and async reset.
module tb_drg_multi;
  localparam int CH = 3;
  localparam int W  = 32;

  logic          clk, rst;
  logic          cfg_wen, cfg_commit;
  logic [1:0]    cfg_ch;
  logic [2:0]    cfg_addr;
  logic [W-1:0]  cfg_wdata;
  logic [CH-1:0] run_en, restart;
  logic [CH*W-1:0] ramp_out;
  logic [CH-1:0] ramp_wrap, ramp_done;

  drg_multi #(.CH_NUM(CH), .WIDTH(W), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .run_en(run_en), .restart(restart),
    .ramp_out(ramp_out), .ramp_wrap(ramp_wrap), .ramp_done(ramp_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  string cur_name = "reset";

  // scoreboard entry: {ch[1:0], out[31:0], wrap, done}
  logic [35:0] exp_q[$];

  function automatic logic [W-1:0] out_of(input int ch);
    return ramp_out[ch*W +: W];
  endfunction

  task automatic check_val(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input int ch, input logic [W-1:0] out, input logic wrap, input logic done);
    exp_q.push_back({ch[1:0], out, wrap, done});
  endtask

  task automatic sb_check();
    logic [35:0] e;
    int ch;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ch = int'(e[35:34]);
      check_val($sformatf("%s ch%0d", cur_name, ch),
                96'({out_of(ch), ramp_wrap[ch], ramp_done[ch]}), 96'(e[33:0]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  // driver tasks
  task automatic cfg_write(input int ch, input logic [2:0] addr, input logic [W-1:0] data);
    cfg_wen = 1'b1; cfg_ch = ch[1:0]; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_wen = 1'b0;
  endtask

  task automatic program_ch(input int ch, input logic [W-1:0] s, input logic [W-1:0] e,
                            input logic [W-1:0] st, input logic [W-1:0] dw, input logic [1:0] m);
    cfg_write(ch, 3'd0, s);
    cfg_write(ch, 3'd1, e);
    cfg_write(ch, 3'd2, st);
    cfg_write(ch, 3'd3, dw);
    cfg_write(ch, 3'd4, W'(m));
  endtask

  typedef struct {
    logic         commit;
    logic         run;
    logic         rs;
    logic [W-1:0] out;
    logic         wrap;
    logic         done;
  } vec_t;

  vec_t saw_v[11];
  int unsigned tri_out[8];
  logic        tri_wr[8];

  initial begin
    saw_v = '{
      '{1'b1, 1'b1, 1'b0, 32'd10, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd10, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd20, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd20, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd30, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd30, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd40, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd40, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 32'd10, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 32'd10, 1'b0, 1'b0}
    };
`ifdef DRG_TRIANGLE_EN
    tri_out = '{10, 20, 25, 15, 5, 0, 10, 20};
    tri_wr  = '{0, 0, 0, 0, 0, 1, 0, 0};
`else
    tri_out = '{10, 20, 0, 10, 20, 0, 10, 20};
    tri_wr  = '{0, 0, 1, 0, 0, 1, 0, 0};
`endif

    rst = 1'b1; cfg_wen = 1'b0; cfg_commit = 1'b0; cfg_ch = '0; cfg_addr = '0;
    cfg_wdata = '0; run_en = '0; restart = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_val("reset ramp_out", 96'(ramp_out), 96'd0);
    check_val("reset ramp_wrap", 96'(ramp_wrap), 96'd0);
    check_val("reset ramp_done", 96'(ramp_done), 96'd0);

    // sawtooth, table-driven
    cur_name = "saw";
    program_ch(0, 32'd10, 32'd40, 32'd10, 32'd1, 2'd0);
    for (int i = 0; i < 11; i++) begin
      cfg_commit = saw_v[i].commit;
      run_en     = {2'b00, saw_v[i].run};
      restart    = {2'b00, saw_v[i].rs};
      push(0, saw_v[i].out, saw_v[i].wrap, saw_v[i].done);
      if (i == 0) begin
        push(1, 32'd0, 1'b0, 1'b0);
        push(2, 32'd0, 1'b0, 1'b0);
      end
      tick();
    end
    cfg_commit = 1'b0; run_en = '0; restart = '0;

    // triangle (or sawtooth fallback)
    cur_name = "tri";
    program_ch(0, 32'd0, 32'd25, 32'd10, 32'd0, 2'd1);
    cfg_commit = 1'b1; run_en = 3'b001;
    push(0, 32'd0, 1'b0, 1'b0);
    tick();
    cfg_commit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(0, tri_out[i], tri_wr[i], 1'b0);
      tick();
    end
    run_en = '0;

    // single-shot with carry clamp
    cur_name = "single";
    program_ch(0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 32'd0, 2'd2);
    cfg_commit = 1'b1; run_en = 3'b001;
    push(0, 32'hFFFF_FFF0, 1'b0, 1'b0); tick();
    cfg_commit = 1'b0;
    push(0, 32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    push(0, 32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    push(0, 32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    restart = 3'b001;
    push(0, 32'hFFFF_FFF0, 1'b0, 1'b0); tick();
    restart = '0;
    push(0, 32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    run_en = '0;

    // START >= END in single-shot: done on first step event, out holds
    cur_name = "degenerate";
    program_ch(0, 32'd20, 32'd10, 32'd1, 32'd2, 2'd2);
    cfg_commit = 1'b1; run_en = 3'b001;
    push(0, 32'd20, 1'b0, 1'b0); tick();
    cfg_commit = 1'b0;
    push(0, 32'd20, 1'b0, 1'b0); tick();
    push(0, 32'd20, 1'b0, 1'b0); tick();
    push(0, 32'd20, 1'b0, 1'b1); tick();
    push(0, 32'd20, 1'b0, 1'b1); tick();
    run_en = '0;

    // shadow writes mid-ramp take effect only at commit
    cur_name = "shadow";
    program_ch(0, 32'd0, 32'd100, 32'd1, 32'd0, 2'd0);
    cfg_commit = 1'b1; run_en = 3'b001;
    push(0, 32'd0, 1'b0, 1'b0); tick();
    cfg_commit = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push(0, W'(i), 1'b0, 1'b0); tick();
    end
    cfg_wen = 1'b1; cfg_ch = 2'd0; cfg_addr = 3'd2; cfg_wdata = 32'd5;
    push(0, 32'd4, 1'b0, 1'b0); tick();
    cfg_addr = 3'd0; cfg_wdata = 32'd50;
    push(0, 32'd5, 1'b0, 1'b0); tick();
    cfg_wen = 1'b0;
    push(0, 32'd6, 1'b0, 1'b0); tick();
    cfg_commit = 1'b1; restart = 3'b001;
    push(0, 32'd50, 1'b0, 1'b0); tick();
    cfg_commit = 1'b0; restart = '0;
    push(0, 32'd55, 1'b0, 1'b0); tick();
    push(0, 32'd60, 1'b0, 1'b0); tick();
    run_en = '0;

    // channel isolation and ignored out-of-range channel select
    cur_name = "isolation";
    program_ch(1, 32'd100, 32'd200, 32'd3, 32'd0, 2'd0);
    program_ch(2, 32'd7, 32'd9, 32'd1, 32'd0, 2'd0);
    cfg_commit = 1'b1; run_en = 3'b010;
    push(0, 32'd50, 1'b0, 1'b0); push(1, 32'd100, 1'b0, 1'b0); push(2, 32'd7, 1'b0, 1'b0);
    tick();
    cfg_commit = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      push(0, 32'd50, 1'b0, 1'b0); push(1, W'(100 + 3*i), 1'b0, 1'b0); push(2, 32'd7, 1'b0, 1'b0);
      tick();
    end
    run_en = '0;
    cfg_write(3, 3'd0, 32'd999);
    cfg_commit = 1'b1;
    push(0, 32'd50, 1'b0, 1'b0); push(1, 32'd100, 1'b0, 1'b0); push(2, 32'd7, 1'b0, 1'b0);
    tick();
    cfg_commit = 1'b0; run_en = 3'b010;
    push(1, 32'd103, 1'b0, 1'b0);
    tick();

    // async reset between edges
    cur_name = "async_rst";
    #2 rst = 1'b1;
    #1;
    check_val("async_rst ramp_out", 96'(ramp_out), 96'd0);
    check_val("async_rst ramp_wrap", 96'(ramp_wrap), 96'd0);
    check_val("async_rst ramp_done", 96'(ramp_done), 96'd0);
    #1 rst = 1'b0;
    run_en = 3'b111;
    push(0, 32'd0, 1'b0, 1'b0); push(1, 32'd0, 1'b0, 1'b0); push(2, 32'd0, 1'b0, 1'b0);
    tick();
    run_en = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
